// File: rtl/bench_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : bench_sequencer
//  Description : Runs a shared benchmark datapath once per condition, times
//                each run in sysclk cycles, with a per-run timeout. Keeps the
//                per-condition times, their saturating total and the index of
//                the fastest non-timed-out condition.
//  Revision    : 1.0 - initial release
// ============================================================================
module bench_sequencer #(
    parameter int          NUM_COND     = 5,
    parameter logic [15:0] OPS_PER_COND = 16'd1024,
    parameter logic [31:0] TIMEOUT_CYC  = 32'd1_000_000
) (
    input  logic                sysclk,
    input  logic                rst,
    input  logic                start,
    output logic                dp_start,
    output logic [2:0]          dp_sel,
    output logic [15:0]         dp_ops,
    input  logic                dp_done,
    input  logic [2:0]          rd_idx,
    output logic [31:0]         rd_time,
    output logic [31:0]         t_total,
    output logic                busy,
    output logic                done,
    output logic [2:0]          winner_code,
    output logic [NUM_COND-1:0] led_onehot,
    output logic [NUM_COND-1:0] timeout_flags
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LAUNCH = 3'd1,
        S_WAIT   = 3'd2,
        S_RECORD = 3'd3,
        S_FINISH = 3'd4
    } state_t;

    localparam logic [2:0]  c_last_idx  = 3'(NUM_COND - 1);
    localparam logic [2:0]  c_no_winner = 3'd7;
    localparam logic [31:0] c_sat       = 32'hFFFF_FFFF;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [2:0]          r_cond_idx;
    logic [31:0]         r_timer;
    logic [31:0]         r_times [NUM_COND];
    logic [31:0]         r_cur_time;
    logic [31:0]         r_best_time;
    logic [31:0]         r_t_total;
    logic [2:0]          r_winner;
    logic [NUM_COND-1:0] r_timeout_flags;

    logic [31:0]         w_timer_inc;
    logic                w_timeout;
    logic                w_last_cond;
    logic                w_new_best;
    logic [32:0]         w_sum;

    // The elapsed count including the current cycle; used both for the
    // recorded time and for the timeout compare.
    assign w_timer_inc = r_timer + 32'd1;
    assign w_timeout   = w_timer_inc >= TIMEOUT_CYC;
    assign w_last_cond = r_cond_idx >= c_last_idx;
    assign w_sum       = {1'b0, r_t_total} + {1'b0, r_cur_time};
    // A timed-out run never wins; strict compare keeps the lower index on ties.
    assign w_new_best  = !r_timeout_flags[r_cond_idx] &&
                         ((r_winner == c_no_winner) || (r_cur_time < r_best_time));

    assign dp_sel        = r_cond_idx;
    assign dp_ops        = OPS_PER_COND;
    assign t_total       = r_t_total;
    assign winner_code   = r_winner;
    assign timeout_flags = r_timeout_flags;

    // State register; reset aborts any run in progress.
    always_ff @(posedge sysclk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and state-decoded outputs.
    always_comb begin
        w_state_nxt = r_state;
        dp_start    = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                dp_start    = 1'b1;
                busy        = 1'b1;
                w_state_nxt = S_WAIT;
            end
            S_WAIT: begin
                busy = 1'b1;
                if (dp_done || w_timeout) begin
                    w_state_nxt = S_RECORD;
                end
            end
            S_RECORD: begin
                busy        = 1'b1;
                w_state_nxt = w_last_cond ? S_FINISH : S_LAUNCH;
            end
            S_FINISH: begin
                done = 1'b1;
                if (start) begin
                    w_state_nxt = S_LAUNCH;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Timer, per-condition times, running total and winner tracking.
    always_ff @(posedge sysclk) begin
        if (rst) begin
            r_cond_idx      <= 3'd0;
            r_timer         <= 32'd0;
            r_cur_time      <= 32'd0;
            r_best_time     <= c_sat;
            r_t_total       <= 32'd0;
            r_winner        <= c_no_winner;
            r_timeout_flags <= '0;
            for (int i = 0; i < NUM_COND; i++) begin
                r_times[i] <= 32'd0;
            end
        end else begin
            case (r_state)
                S_IDLE, S_FINISH: begin
                    if (start) begin
                        r_cond_idx      <= 3'd0;
                        r_cur_time      <= 32'd0;
                        r_best_time     <= c_sat;
                        r_t_total       <= 32'd0;
                        r_winner        <= c_no_winner;
                        r_timeout_flags <= '0;
                        for (int i = 0; i < NUM_COND; i++) begin
                            r_times[i] <= 32'd0;
                        end
                    end
                end
                S_LAUNCH: begin
                    r_timer <= 32'd0;
                end
                S_WAIT: begin
                    r_timer <= w_timer_inc;
                    if (dp_done) begin
                        r_times[r_cond_idx] <= w_timer_inc;
                        r_cur_time          <= w_timer_inc;
                    end else if (w_timeout) begin
                        r_times[r_cond_idx]         <= c_sat;
                        r_cur_time                  <= c_sat;
                        r_timeout_flags[r_cond_idx] <= 1'b1;
                    end
                end
                S_RECORD: begin
                    r_t_total <= w_sum[32] ? c_sat : w_sum[31:0];
                    if (w_new_best) begin
                        r_winner    <= r_cond_idx;
                        r_best_time <= r_cur_time;
                    end
                    if (!w_last_cond) begin
                        r_cond_idx <= r_cond_idx + 3'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Combinational result read; indices past the last condition read zero.
    always_comb begin
        rd_time = 32'd0;
        for (int i = 0; i < NUM_COND; i++) begin
            if (rd_idx == 3'(i)) begin
                rd_time = r_times[i];
            end
        end
    end

    // Winner display; code 7 never matches a condition so all LEDs stay dark.
    always_comb begin
        led_onehot = '0;
        for (int i = 0; i < NUM_COND; i++) begin
            led_onehot[i] = (r_winner == 3'(i));
        end
    end

endmodule
`default_nettype wire
